// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, error codes,
// keyboard command bytes and the microsecond-to-cycle helper.
package ps2_host_tx_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_WAIT_FIRST,
        ST_BITS,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_START = 2'd1,
        ERR_FRAME = 2'd2,
        ERR_NOACK = 2'd3
    } err_code_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    function automatic logic [CNT_W-1:0] us_to_cyc(input int clk_hz, input int us);
        return CNT_W'(clk_hz / 1_000_000 * us);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter: byte request plus
// busy/done/err status back to the requester.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, err, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, err, err_code
    );
endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-FF synchronizers on both lines, a run-length glitch
// filter on the clock and a one-cycle strobe on each filtered falling edge.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_filt,
    output logic data_sync,
    output logic clk_fall
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_meta;
    logic [1:0]    data_meta;
    logic [FW-1:0] run_cnt;

    assign data_sync = data_meta[1];

    // NOTE: non-blocking assignments keep each meta stage one clock behind the
    // previous one; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
            clk_filt  <= 1'b1;
            run_cnt   <= '0;
            clk_fall  <= 1'b0;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk_i};
            data_meta <= {data_meta[0], ps2_data_i};
            clk_fall  <= 1'b0;
            // A new level is taken only after FILTER_LEN consecutive samples of it.
            if (clk_meta[1] != clk_filt) begin
                if (run_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_meta[1];
                    clk_fall <= clk_filt;
                    run_cnt  <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 host-driven bits
// clocked by the device, ACK check and return-to-idle, each phase timed out.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    // The RTS cycle is the last cycle of the inhibit window, so the clock is held
    // low for exactly INHIBIT_CYC cycles in total.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US) - CNT_W'(2);
    localparam logic [CNT_W-1:0] START_LOAD   = us_to_cyc(CLK_FREQ_HZ, START_TIMEOUT_US) - CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_LOAD   = us_to_cyc(CLK_FREQ_HZ, FRAME_TIMEOUT_US) - CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic             clk_filt;
    logic             data_sync;
    logic             clk_fall;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_filt   (clk_filt),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    assign cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx.tx_ready <= 1'b1;
            tx.busy     <= 1'b0;
            tx.done     <= 1'b0;
            tx.err      <= 1'b0;
            tx.err_code <= ERR_NONE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx.done <= 1'b0;
            tx.err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (tx.tx_valid) begin
                        // Shift order: d[0]..d[7], odd parity, then the stop bit.
                        shreg       <= {1'b1, ~^tx.tx_data, tx.tx_data};
                        cnt         <= INHIBIT_LOAD;
                        ps2_clk_oe  <= 1'b1;
                        tx.tx_ready <= 1'b0;
                        tx.busy     <= 1'b1;
                        tx.err_code <= ERR_NONE;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == '0) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_RTS;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                ST_RTS: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= START_LOAD;
                    state      <= ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= shreg >> 1;
                        bit_cnt     <= '0;
                        cnt         <= FRAME_LOAD;
                        state       <= ST_BITS;
                    end else if (cnt == '0) begin
                        ps2_data_oe <= 1'b0;
                        tx.err      <= 1'b1;
                        tx.err_code <= ERR_START;
                        state       <= ST_ERR;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                ST_BITS: begin
                    cnt <= cnt_dec;
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= shreg >> 1;
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd8) state <= ST_WAIT_ACK;
                    end else if (cnt == '0) begin
                        ps2_data_oe <= 1'b0;
                        tx.err      <= 1'b1;
                        tx.err_code <= ERR_FRAME;
                        state       <= ST_ERR;
                    end
                end
                ST_WAIT_ACK: begin
                    cnt <= cnt_dec;
                    if (clk_fall) begin
                        if (!data_sync) begin
                            state <= ST_WAIT_IDLE;
                        end else begin
                            tx.err      <= 1'b1;
                            tx.err_code <= ERR_NOACK;
                            state       <= ST_ERR;
                        end
                    end else if (cnt == '0) begin
                        tx.err      <= 1'b1;
                        tx.err_code <= ERR_FRAME;
                        state       <= ST_ERR;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= cnt_dec;
                    if (clk_filt && data_sync) begin
                        tx.done <= 1'b1;
                        state   <= ST_DONE;
                    end else if (cnt == '0) begin
                        tx.err      <= 1'b1;
                        tx.err_code <= ERR_FRAME;
                        state       <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    tx.tx_ready <= 1'b1;
                    tx.busy     <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks the frame,
// a scoreboard queue holds the expected done/err response of each command.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx_if bus ();

    logic dev_clk_rel  = 1'b1;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_pin, ps2_data_pin;
    assign ps2_clk_pin  = dev_clk_rel & ~ps2_clk_oe;
    assign ps2_data_pin = ~dev_data_low & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (1_000_000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (1000),
        .FRAME_TIMEOUT_US (500),
        .FILTER_LEN       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (bus),
        .ps2_clk_i   (ps2_clk_pin),
        .ps2_data_i  (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic        chk_frame;
        logic [10:0] frame;   // [0]=start, [8:1]=data, [9]=parity, [10]=stop
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_pulse = 0;
    logic [10:0] cap;
    int          inh_len;
    int unsigned rts_cyc;
    int unsigned fall1_cyc;
    int          dev_falls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && (bus.done || bus.err)) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.done, bus.err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_kind", {30'd0, bus.done, bus.err}, e.is_err ? 32'd1 : 32'd2);
                if (e.is_err)
                    check("err_code", {30'd0, bus.err_code}, {30'd0, e.code});
                else if (e.chk_frame)
                    check("dev_frame", {21'd0, cap}, {21'd0, e.frame});
            end
        end
    end

    // Device model: measures the inhibit window, detects RTS, then clocks
    // n_falls falling edges at 20 low / 20 high, sampling data on rising edges.
    task automatic device(input int n_falls, input bit ack, input int glitch_after);
        int k;
        dev_falls = 0;
        k = 0;
        while (!ps2_clk_oe && k < 200) begin @(negedge clk); k++; end
        inh_len = 0;
        while (ps2_clk_oe && inh_len < 300) begin @(negedge clk); inh_len++; end
        rts_cyc = cyc;
        if (n_falls == 0) return;
        repeat (10) @(negedge clk);
        cap    = '0;
        cap[0] = ps2_data_pin;
        for (int f = 1; f <= n_falls; f++) begin
            if (f == 11 && ack) dev_data_low = 1'b1;
            dev_clk_rel = 1'b0;
            dev_falls   = f;
            if (f == 1) fall1_cyc = cyc;
            repeat (20) @(negedge clk);
            dev_clk_rel = 1'b1;
            if (f <= 10) cap[f] = ps2_data_pin;
            if (f == glitch_after) begin
                repeat (6) @(negedge clk);
                dev_clk_rel = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk_rel = 1'b1;
                repeat (11) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            if (f == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_resp(input int budget, output int unsigned at);
        int k = 0;
        while (!(bus.done || bus.err) && k < budget) begin @(negedge clk); k++; end
        at = cyc;
        if (!(bus.done || bus.err)) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            check("pulse_busy_ready", {30'd0, bus.busy, bus.tx_ready}, 32'd2);
            @(negedge clk);
            check("post_busy_ready", {30'd0, bus.busy, bus.tx_ready}, 32'd1);
            check("post_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin : stim
        int unsigned at;
        int          p;
        int          k;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready_busy", {30'd0, bus.tx_ready, bus.busy}, 32'd2);
        check("rst_done_err",   {30'd0, bus.done, bus.err}, 32'd0);
        check("rst_err_code",   {30'd0, bus.err_code}, 32'd0);
        check("rst_oe",         {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED: LSB-first 1,0,1,1,0,1,1,1, parity 1
        sb_q.push_back('{1'b0, 2'd0, 1'b1, 11'b1_1_11101101_0});
        fork
            device(11, 1'b1, 0);
            begin send(CMD_SET_LED); wait_resp(2000, at); end
        join
        check("inhibit_len", inh_len, 32'd100);
        repeat (5) @(negedge clk);

        // 0xF4: parity 0
        sb_q.push_back('{1'b0, 2'd0, 1'b1, 11'b1_0_11110100_0});
        fork
            device(11, 1'b1, 0);
            begin send(CMD_ENABLE); wait_resp(2000, at); end
        join
        repeat (5) @(negedge clk);

        // 0xFF with a 3-cycle clock glitch after fall 4
        sb_q.push_back('{1'b0, 2'd0, 1'b1, 11'b1_1_11111111_0});
        fork
            device(11, 1'b1, 4);
            begin send(CMD_RESET); wait_resp(2000, at); end
        join
        repeat (5) @(negedge clk);

        // Device never clocks: start timeout
        sb_q.push_back('{1'b1, 2'd1, 1'b0, 11'd0});
        fork
            device(0, 1'b0, 0);
            begin send(CMD_SET_LED); wait_resp(3000, at); end
        join
        check("start_timeout_cyc", at - rts_cyc, 32'd1000);
        repeat (5) @(negedge clk);

        // Data left high at fall 11: no ACK
        sb_q.push_back('{1'b1, 2'd3, 1'b0, 11'd0});
        fork
            device(11, 1'b0, 0);
            begin send(CMD_ENABLE); wait_resp(2000, at); end
        join
        repeat (5) @(negedge clk);

        // Clock stops after fall 5: frame timeout ~500 cycles after fall 1
        sb_q.push_back('{1'b1, 2'd2, 1'b0, 11'd0});
        fork
            device(5, 1'b1, 0);
            begin send(CMD_RESET); wait_resp(2000, at); end
        join
        check("frame_timeout_win",
              {31'd0, (at - fall1_cyc >= 500) && (at - fall1_cyc <= 520)}, 32'd1);
        repeat (5) @(negedge clk);

        // Reset in the middle of BITS
        fork
            device(11, 1'b1, 0);
            begin
                send(CMD_SET_LED);
                k = 0;
                while (dev_falls < 3 && k < 1000) begin @(negedge clk); k++; end
                check("reached_bits", {31'd0, dev_falls >= 3}, 32'd1);
                repeat (25) @(negedge clk);
                p   = n_pulse;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check("midrst_oe",         {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                check("midrst_ready_busy", {30'd0, bus.tx_ready, bus.busy}, 32'd2);
            end
        join
        repeat (20) @(negedge clk);
        check("midrst_no_pulse", n_pulse - p, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
